// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the multicycle controller's MemRead/MemWrite strobes.
// Each access: WAIT_CYCLES busy cycles, then a one-cycle mem_ready; level requests are re-armed only after they drop.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                op_rd_q, op_wr_q, err_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   ram [0:DEPTH-1];

  logic                req;
  logic                sel_rd, sel_wr, sel_oor, sel_illegal;
  logic [31:0]         sel_addr;

  assign req = mem_read | mem_write;

  // With zero wait states DONE is entered straight from IDLE, so the live inputs
  // describe the access being completed; otherwise the latched copies do.
  always_comb begin
    sel_rd      = (state == IDLE) ? mem_read  : op_rd_q;
    sel_wr      = (state == IDLE) ? mem_write : op_wr_q;
    sel_addr    = (state == IDLE) ? addr      : addr_q;
    sel_oor     = |sel_addr[31:ADDR_W];
    sel_illegal = sel_rd & sel_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY: if (cnt <= 4'd1) state_nxt = DONE;
      DONE: state_nxt = HOLD;
      HOLD: if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == DONE);
    mem_busy  = (state == BUSY) || (state == DONE);
    mem_err   = (state == DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_rd_q <= mem_read;
        op_wr_q <= mem_write;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= WAIT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == DONE && state != DONE) begin
        err_q <= sel_oor | sel_illegal;
        if (sel_rd && !sel_wr) begin
          rdata <= sel_oor ? '0 : ram[sel_addr[ADDR_W-1:0]];
        end
      end
    end
  end

  // Commit on the edge leaving DONE; a coincident reset wins and drops the write.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && op_wr_q && !op_rd_q && !(|addr_q[31:ADDR_W])) begin
      ram[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed vector bench: a 2-wait-state instance and a 0-wait-state instance share the request inputs.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_t, rdata_z;
  logic        ready_t, busy_t, err_t;
  logic        ready_z, busy_z, err_z;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut_t (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_t), .mem_ready(ready_t),
    .mem_busy(busy_t), .mem_err(err_t)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata_z), .mem_ready(ready_z),
    .mem_busy(busy_z), .mem_err(err_z)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, waits for completion, checks latency/err/rdata, then drops
  // the strobes and waits until the responder is back in IDLE.
  task automatic access(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_err, input logic [31:0] exp_rd,
                        input string tag, input int hold_extra);
    int n;
    int pulses;
    bit got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = z ? ready_z : ready_t;
    end
    check({tag, " latency"}, n, z ? 1 : 3);
    check({tag, " err"}, z ? err_z : err_t, exp_err);
    check({tag, " rdata"}, z ? rdata_z : rdata_t, exp_rd);
    check({tag, " busy in done"}, z ? busy_z : busy_t, 1);
    if (hold_extra > 0) begin
      pulses = 0;
      for (int i = 0; i < hold_extra; i++) begin
        @(negedge clk);
        if (z ? ready_z : ready_t) pulses++;
      end
      check({tag, " extra pulses"}, pulses, 0);
      check({tag, " busy in hold"}, z ? busy_z : busy_t, 0);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " busy idle"}, z ? busy_z : busy_t, 0);
  endtask

  // Write 7 <= d, then reset k negedges after the request was driven.
  task automatic reset_during(input int k, input logic [31:0] d, input bit exp_ready, input string tag);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'd7; wdata = d;
    repeat (k) @(negedge clk);
    check({tag, " ready before reset"}, ready_t, exp_ready);
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    check({tag, " rdata after reset"}, rdata_t, 0);
    check({tag, " ready after reset"}, ready_t, 0);
    check({tag, " busy after reset"}, busy_t, 0);
    check({tag, " err after reset"}, err_t, 0);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0000};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h2222_2222, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h3333_3333, 1'b1, 32'h1111_1111};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_ABCD, 1'b0, 32'h1111_1111};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,         1'b0, 32'h0000_ABCD};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_00FF, 32'h5A5A_5A5A, 1'b0, 32'h0000_ABCD};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_00FF, 32'h0,         1'b0, 32'h5A5A_5A5A};
    tbl[12] = '{1'b1, 1'b0, 32'h8000_0005, 32'h0,         1'b1, 32'h0000_0000};

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset rdata", rdata_t, 0);
    check("reset ready", ready_t, 0);
    check("reset busy", busy_t, 0);
    check("reset err", err_t, 0);
    check("reset rdata z", rdata_z, 0);
    check("reset ready z", ready_z, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].err, tbl[i].exp_rd,
             $sformatf("vec%0d", i), 0);
    end

    // Held read strobe: exactly one completion, then a fresh request is accepted.
    access(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEAD_BEEF, "held read", 10);
    access(1'b0, 1'b1, 1'b0, 32'd255, 32'h0, 1'b0, 32'h5A5A_5A5A, "after hold", 0);

    // Writes cut short by reset in BUSY and in DONE must not reach RAM.
    reset_during(1, 32'h0000_1234, 1'b0, "rst busy");
    access(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0000_ABCD, "read after busy rst", 0);
    reset_during(3, 32'h0000_9999, 1'b1, "rst done");
    access(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0000_ABCD, "read after done rst", 0);

    // Zero-wait-state instance: read / write / read of one word.
    access(1'b1, 1'b1, 1'b0, 32'd5, 32'h0,         1'b0, 32'hDEAD_BEEF, "z read", 0);
    access(1'b1, 1'b0, 1'b1, 32'd5, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, "z write", 0);
    access(1'b1, 1'b1, 1'b0, 32'd5, 32'h0,         1'b0, 32'hCAFE_F00D, "z read new", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
